// File: rtl/dac_playback_engine.sv
// DAC playback engine: buffers up to DEPTH stream words, then replays them N times per trigger
// framed by locking-waveform pre/post delays. Optional marker output under DAC_PLAYBACK_MARKER_EN.
module dac_playback_engine #(
  parameter int unsigned SAMPLE_BITS      = 16,
  parameter int unsigned SAMPLES_PER_WORD = 16,
  parameter int unsigned DEPTH            = 64,
  parameter int unsigned CNT_BITS         = 32,
  parameter int unsigned GPIO_BITS        = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [GPIO_BITS-1:0]                    gpio_ctrl,
  input  logic                                    select_in,
  input  logic                                    trigger_in,
  input  logic [SAMPLE_BITS*SAMPLES_PER_WORD-1:0] s_axis_tdata,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  output logic [SAMPLE_BITS*SAMPLES_PER_WORD-1:0] m_axis_tdata,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic                                    busy,
  output logic                                    trig_overrun
`ifdef DAC_PLAYBACK_MARKER_EN
  ,
  output logic                                    marker_out
`endif
);

  localparam int unsigned DW = SAMPLE_BITS * SAMPLES_PER_WORD;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  // gpio_ctrl bit assignment: bit 0 carries serial data, the rest are shift strobes
  localparam int unsigned G_SDATA   = 0;
  localparam int unsigned G_MUX     = 1;
  localparam int unsigned G_MASK_EN = 2;
  localparam int unsigned G_CYCLE   = 3;
  localparam int unsigned G_PRE     = 4;
  localparam int unsigned G_POST    = 5;
  localparam int unsigned G_MASK    = 6;
  localparam int unsigned G_LOCK    = 7;
  localparam int unsigned G_USED    = 8;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PLAY, S_POST} state_t;

  state_t              r_state, w_state_nxt;
  logic [G_USED-1:0]   r_g_s1, r_g_s2, r_g_s3;
  logic [G_USED-1:0]   w_rise;
  logic                w_sdata;
  logic                r_mux_sel, r_mask_en;
  logic [CNT_BITS-1:0] r_cycle_count, r_pre_delay, r_post_delay;
  logic [DW-1:0]       r_mask, r_lock_wf;
  logic [LW-1:0]       r_wr_ptr, w_wr_ptr_nxt, r_len;
  logic                r_s_tready;
  logic [DW-1:0]       r_buf [DEPTH];
  logic [AW-1:0]       r_rd_ptr, w_rd_nxt;
  logic [DW-1:0]       r_rd_data;
  logic [CNT_BITS-1:0] r_cnt, r_rep, r_post_sh;
  logic                r_trig_d, r_overrun;
  logic                w_trig, w_start, w_beat, w_last, w_load_beat;
  logic                w_mux_nxt, w_mux_rise, w_mux_fall;
  logic                w_unused_gpio;

  generate
    if (GPIO_BITS > G_USED) begin : g_unused_hi
      assign w_unused_gpio = ^{w_rise[G_SDATA], gpio_ctrl[GPIO_BITS-1:G_USED]};
    end else begin : g_unused_lo
      assign w_unused_gpio = w_rise[G_SDATA];
    end
  endgenerate

  // Two-flop synchroniser plus edge history for the config bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_g_s1 <= '0;
      r_g_s2 <= '0;
      r_g_s3 <= '0;
    end else begin
      r_g_s1 <= gpio_ctrl[G_USED-1:0];
      r_g_s2 <= r_g_s1;
      r_g_s3 <= r_g_s2;
    end
  end

  assign w_rise  = r_g_s2 & ~r_g_s3 & {G_USED{select_in}};
  assign w_sdata = r_g_s2[G_SDATA];

  // LSB-first serial config registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mux_sel     <= 1'b0;
      r_mask_en     <= 1'b0;
      r_cycle_count <= '0;
      r_pre_delay   <= '0;
      r_post_delay  <= '0;
      r_mask        <= '0;
      r_lock_wf     <= '0;
    end else begin
      if (w_rise[G_MUX])     r_mux_sel     <= w_sdata;
      if (w_rise[G_MASK_EN]) r_mask_en     <= w_sdata;
      if (w_rise[G_CYCLE])   r_cycle_count <= {w_sdata, r_cycle_count[CNT_BITS-1:1]};
      if (w_rise[G_PRE])     r_pre_delay   <= {w_sdata, r_pre_delay[CNT_BITS-1:1]};
      if (w_rise[G_POST])    r_post_delay  <= {w_sdata, r_post_delay[CNT_BITS-1:1]};
      if (w_rise[G_MASK])    r_mask        <= {w_sdata, r_mask[DW-1:1]};
      if (w_rise[G_LOCK])    r_lock_wf     <= {w_sdata, r_lock_wf[DW-1:1]};
    end
  end

  assign w_mux_nxt   = w_rise[G_MUX] ? w_sdata : r_mux_sel;
  assign w_mux_rise  = w_rise[G_MUX] &  w_sdata & ~r_mux_sel;
  assign w_mux_fall  = w_rise[G_MUX] & ~w_sdata &  r_mux_sel;
  assign w_load_beat = r_s_tready & s_axis_tvalid;

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    if (w_mux_fall)       w_wr_ptr_nxt = '0;
    else if (w_load_beat) w_wr_ptr_nxt = r_wr_ptr + LW'(1);
  end

  // Load side: write pointer, ready flag, and length latched on entry to play mode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_len      <= '0;
      r_s_tready <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_s_tready <= ~w_mux_nxt & (w_wr_ptr_nxt != LW'(DEPTH));
      if (w_mux_rise) r_len <= w_wr_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (w_load_beat) begin
      r_buf[r_wr_ptr[AW-1:0]] <= s_axis_tdata;
    end
  end

  assign w_trig  = trigger_in & ~r_trig_d;
  assign w_beat  = r_mux_sel & m_axis_tready;
  assign w_last  = ({1'b0, r_rd_ptr} == (r_len - LW'(1)));
  assign w_start = w_trig & r_mux_sel & (r_state == S_IDLE) & ~w_mux_fall
                 & (r_len != '0) & (r_cycle_count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = (r_pre_delay != '0) ? S_PRE : S_PLAY;
      S_PRE:  if (w_beat && r_cnt == CNT_BITS'(1)) w_state_nxt = S_PLAY;
      S_PLAY: if (w_beat && w_last && r_rep == CNT_BITS'(1))
                w_state_nxt = (r_post_sh != '0) ? S_POST : S_IDLE;
      S_POST: if (w_beat && r_cnt == CNT_BITS'(1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_mux_fall) w_state_nxt = S_IDLE;
  end

  always_comb begin
    m_axis_tdata = r_lock_wf;
    busy         = (r_state != S_IDLE);
`ifdef DAC_PLAYBACK_MARKER_EN
    marker_out   = (r_state == S_PLAY) && (r_rd_ptr == '0);
`endif
    if (!r_mux_sel)               m_axis_tdata = '0;
    else if (r_state == S_PLAY)   m_axis_tdata = r_mask_en ? (r_rd_data & r_mask) : r_rd_data;
  end

  assign m_axis_tvalid = r_mux_sel;
  assign s_axis_tready = r_s_tready;
  assign trig_overrun  = r_overrun;

  // Read pointer look-ahead so the prefetched word is always buf[rd_ptr]
  always_comb begin
    w_rd_nxt = r_rd_ptr;
    if (w_start)                           w_rd_nxt = '0;
    else if (r_state == S_PLAY && w_beat)  w_rd_nxt = w_last ? '0 : r_rd_ptr + AW'(1);
    if (w_mux_fall)                        w_rd_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr  <= '0;
      r_rd_data <= '0;
      r_cnt     <= '0;
      r_rep     <= '0;
      r_post_sh <= '0;
      r_trig_d  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_trig_d  <= trigger_in;
      r_rd_ptr  <= w_rd_nxt;
      r_rd_data <= r_buf[w_rd_nxt];
      if (w_start) begin
        r_cnt     <= r_pre_delay;
        r_rep     <= r_cycle_count;
        r_post_sh <= r_post_delay;
      end else if (w_beat) begin
        case (r_state)
          S_PRE, S_POST: r_cnt <= r_cnt - CNT_BITS'(1);
          S_PLAY: if (w_last) begin
            r_rep <= r_rep - CNT_BITS'(1);
            if (r_rep == CNT_BITS'(1)) r_cnt <= r_post_sh;
          end
          default: ;
        endcase
      end
      if (w_trig && r_mux_sel && !w_start) r_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dac_playback_engine.sv
// Directed bench for dac_playback_engine: load, one-shot, backpressure, repeat+mask,
// overrun, full buffer and abort.
module tb_dac_playback_engine;

  localparam int unsigned DW    = 256;
  localparam int unsigned DEPTH = 64;
  localparam int G_MUX = 1, G_MASK_EN = 2, G_CYCLE = 3, G_PRE = 4, G_POST = 5;
  localparam int G_MASK = 6, G_LOCK = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   gpio_ctrl;
  logic          select_in, trigger_in;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready;
  logic          busy, trig_overrun;
`ifdef DAC_PLAYBACK_MARKER_EN
  logic          marker_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] cap_q [$];
  bit            cap_done;

  always #5 clk = ~clk;

  dac_playback_engine dut (
    .clk(clk), .rst(rst), .gpio_ctrl(gpio_ctrl), .select_in(select_in),
    .trigger_in(trigger_in), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .busy(busy), .trig_overrun(trig_overrun)
`ifdef DAC_PLAYBACK_MARKER_EN
    , .marker_out(marker_out)
`endif
  );

  function automatic logic [DW-1:0] rep16(input logic [15:0] s);
    return {16{s}};
  endfunction

  function automatic logic [DW-1:0] qget(input int i);
    if (i < cap_q.size()) return cap_q[i];
    return 'x;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Serially shifts nbits of val, LSB first, with one strobe pulse per bit
  task automatic gpio_write(input int idx, input logic [DW-1:0] val, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      @(negedge clk);
      gpio_ctrl[0]   = val[b];
      gpio_ctrl[idx] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      gpio_ctrl[idx] = 1'b1;
      @(negedge clk);
      @(negedge clk);
    end
    gpio_ctrl[idx] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] w, output bit acc);
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    acc = s_axis_tready;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  // Triggers one run and records every delivered beat until busy drops
  task automatic run_play(input bit bp, input int retrig);
    cap_q.delete();
    cap_done = 1'b0;
    trigger_in = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      trigger_in = (i == retrig);
      if (!busy) begin
        cap_done = 1'b1;
        break;
      end
      m_axis_tready = bp ? (i % 2 == 1) : 1'b1;
      if (m_axis_tready) cap_q.push_back(m_axis_tdata);
    end
    trigger_in    = 1'b0;
    m_axis_tready = 1'b1;
    chk("run_done", DW'(cap_done), DW'(1));
  endtask

  initial begin
    logic [DW-1:0] lock, wa, wb, wc, wd, mask, exp;
    logic [DW-1:0] words [3];
    bit acc;
    int n_acc;

    lock = rep16(16'h1111);
    wa = rep16(16'hAAAA); wb = rep16(16'hBBBB); wc = rep16(16'hCCCC); wd = rep16(16'hDDDD);
    mask = {{128{1'b0}}, {128{1'b1}}};
    words[0] = wa; words[1] = wb; words[2] = wc;

    rst = 1'b0; gpio_ctrl = '0; select_in = 1'b1; trigger_in = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_tready", DW'(s_axis_tready), DW'(0));
    chk("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("rst_m_tdata", m_axis_tdata, '0);
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_overrun", DW'(trig_overrun), DW'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("load_s_tready", DW'(s_axis_tready), DW'(1));
    chk("load_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("load_busy", DW'(busy), DW'(0));

    // Trigger with an empty buffer is dropped
    gpio_write(G_CYCLE, DW'(1), 32);
    gpio_write(G_MUX, DW'(1), 1);
    trigger_in = 1'b1;
    @(negedge clk);
    trigger_in = 1'b0;
    @(negedge clk);
    chk("len0_busy", DW'(busy), DW'(0));
    chk("len0_overrun", DW'(trig_overrun), DW'(1));
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_overrun", DW'(trig_overrun), DW'(0));
    rst = 1'b1;
    @(negedge clk);

    // One-shot
    push(wa, acc);
    chk("os_load_acc", DW'(acc), DW'(1));
    gpio_write(G_CYCLE, DW'(1), 32);
    gpio_write(G_PRE, DW'(1), 32);
    gpio_write(G_POST, DW'(1), 32);
    gpio_write(G_LOCK, lock, 256);
    gpio_write(G_MUX, DW'(1), 1);
    chk("play_m_tvalid", DW'(m_axis_tvalid), DW'(1));
    chk("play_s_tready", DW'(s_axis_tready), DW'(0));
    chk("play_idle_tdata", m_axis_tdata, lock);
    run_play(1'b0, -1);
    chk("os_beats", DW'(cap_q.size()), DW'(3));
    chk("os_b0", qget(0), lock);
    chk("os_b1", qget(1), wa);
    chk("os_b2", qget(2), lock);
    chk("os_idle_tdata", m_axis_tdata, lock);

    // Same run under 50% backpressure
    run_play(1'b1, -1);
    chk("bp_beats", DW'(cap_q.size()), DW'(3));
    chk("bp_b0", qget(0), lock);
    chk("bp_b1", qget(1), wa);
    chk("bp_b2", qget(2), lock);
    chk("bp_overrun", DW'(trig_overrun), DW'(0));

    // Repeat with mask: three words, ten repetitions, pre/post of two
    gpio_write(G_MUX, DW'(0), 1);
    chk("rm_s_tready", DW'(s_axis_tready), DW'(1));
    for (int i = 0; i < 3; i++) push(words[i], acc);
    gpio_write(G_CYCLE, DW'(10), 32);
    gpio_write(G_PRE, DW'(2), 32);
    gpio_write(G_POST, DW'(2), 32);
    gpio_write(G_MASK, mask, 256);
    gpio_write(G_MASK_EN, DW'(1), 1);
    gpio_write(G_MUX, DW'(1), 1);
    run_play(1'b0, -1);
    chk("rm_beats", DW'(cap_q.size()), DW'(34));
    for (int i = 0; i < 34; i++) begin
      if (i < 2 || i >= 32) exp = lock;
      else exp = {128'h0, words[(i - 2) % 3][127:0]};
      chk($sformatf("rm_b%0d", i), qget(i), exp);
    end
    chk("rm_overrun", DW'(trig_overrun), DW'(0));

    // Retrigger mid-PLAY is ignored but flagged
    run_play(1'b0, 10);
    chk("rt_beats", DW'(cap_q.size()), DW'(34));
    chk("rt_overrun", DW'(trig_overrun), DW'(1));

    // Full buffer
    gpio_write(G_MUX, DW'(0), 1);
    n_acc = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      push(rep16(16'(i)), acc);
      n_acc += int'(acc);
    end
    chk("full_accepted", DW'(n_acc), DW'(DEPTH));
    chk("full_s_tready", DW'(s_axis_tready), DW'(0));

    // Abort mid-PLAY
    gpio_write(G_CYCLE, DW'(1), 32);
    gpio_write(G_PRE, DW'(0), 32);
    gpio_write(G_POST, DW'(0), 32);
    gpio_write(G_MASK_EN, DW'(0), 1);
    gpio_write(G_MUX, DW'(1), 1);
    trigger_in = 1'b1;
    @(negedge clk);
    trigger_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("ab_play_tdata", m_axis_tdata, rep16(16'd4));
    chk("ab_play_busy", DW'(busy), DW'(1));
    gpio_write(G_MUX, DW'(0), 1);
    chk("ab_busy", DW'(busy), DW'(0));
    chk("ab_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("ab_s_tready", DW'(s_axis_tready), DW'(1));

    // Pointer restarts at 0; pre/post of zero skip straight through PLAY
    push(wd, acc);
    gpio_write(G_MUX, DW'(1), 1);
    run_play(1'b0, -1);
    chk("pz_beats", DW'(cap_q.size()), DW'(1));
    chk("pz_b0", qget(0), wd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
